// File: rtl/iq_sample_packer.sv
// rtl/iq_sample_packer.sv - reduces complex samples to OUT_BITS per component and packs PACK_N per output word
// Optional feature macro: IQ_PACK_ROUND_EN (round half-up with positive saturation instead of truncation)
module iq_sample_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_BITS  = 4,
  parameter int OUT_WIDTH = 32,
  localparam int PACK_N   = OUT_WIDTH / (2 * OUT_BITS),
  localparam int NSAMP_W  = $clog2(PACK_N + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [OUT_WIDTH-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [NSAMP_W-1:0]   o_nsamp
);

  localparam int HALF   = IN_WIDTH / 2;
  localparam int SLOT_W = $clog2(PACK_N);
  localparam int PAIR_W = 2 * OUT_BITS;

  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] o_tdata_q, o_tdata_d;
  logic                 o_tlast_q, o_tlast_d;
  logic                 o_tvalid_q, o_tvalid_d;
  logic [NSAMP_W-1:0]   o_nsamp_q, o_nsamp_d;

  logic                 accept;
  logic                 complete;
  logic [PAIR_W-1:0]    pair;
  logic [OUT_WIDTH-1:0] acc_img;

  // Reduce one signed component to its OUT_BITS most-significant bits.
  function automatic logic [OUT_BITS-1:0] reduce(input logic [HALF-1:0] c);
`ifdef IQ_PACK_ROUND_EN
    logic [HALF-1:0] sum;
    sum = c + (HALF'(1) << (HALF - OUT_BITS - 1));
    // Only a non-negative input can wrap to negative after adding the rounding constant.
    if (!c[HALF-1] && sum[HALF-1]) begin
      reduce = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else begin
      reduce = sum[HALF-1 -: OUT_BITS];
    end
`else
    reduce = c[HALF-1 -: OUT_BITS];
`endif
  endfunction

  // Output register may take a new word whenever it is empty or being drained this cycle.
  assign i_tready = ~o_tvalid_q | o_tready;

  // Slot placement, word completion and output register next-state.
  always_comb begin
    accept   = i_tvalid & i_tready;
    complete = accept & ((slot_q == SLOT_W'(PACK_N - 1)) | i_tlast);
    pair     = {reduce(i_tdata[IN_WIDTH-1 -: HALF]), reduce(i_tdata[HALF-1:0])};

    acc_img = acc_q;
    for (int k = 0; k < PACK_N; k++) begin
      if (slot_q == SLOT_W'(k)) begin
        acc_img[OUT_WIDTH-1-PAIR_W*k -: PAIR_W] = pair;
      end
    end

    slot_d     = slot_q;
    acc_d      = acc_q;
    o_tdata_d  = o_tdata_q;
    o_tlast_d  = o_tlast_q;
    o_tvalid_d = o_tvalid_q;
    o_nsamp_d  = o_nsamp_q;

    if (accept) begin
      if (complete) begin
        slot_d = '0;
        acc_d  = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
        acc_d  = acc_img;
      end
    end

    // A completion wins over a drain so back-to-back words keep o_tvalid high.
    if (complete) begin
      o_tdata_d  = acc_img;
      o_tlast_d  = i_tlast;
      o_nsamp_d  = NSAMP_W'(slot_q) + NSAMP_W'(1);
      o_tvalid_d = 1'b1;
    end else if (o_tready) begin
      o_tvalid_d = 1'b0;
    end
  end

  // State registers; reset drops any partially packed or pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q     <= '0;
      acc_q      <= '0;
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_nsamp_q  <= '0;
    end else begin
      slot_q     <= slot_d;
      acc_q      <= acc_d;
      o_tdata_q  <= o_tdata_d;
      o_tlast_q  <= o_tlast_d;
      o_tvalid_q <= o_tvalid_d;
      o_nsamp_q  <= o_nsamp_d;
    end
  end

  assign o_tdata  = o_tdata_q;
  assign o_tlast  = o_tlast_q;
  assign o_tvalid = o_tvalid_q;
  assign o_nsamp  = o_nsamp_q;

endmodule

// File: tb/tb_iq_sample_packer.sv
// tb/tb_iq_sample_packer.sv - scoreboard bench for iq_sample_packer with randomized traffic
module tb_iq_sample_packer;

  localparam int IN_WIDTH  = 32;
  localparam int OUT_BITS  = 4;
  localparam int OUT_WIDTH = 32;
  localparam int HALF      = IN_WIDTH / 2;
  localparam int PACK_N    = OUT_WIDTH / (2 * OUT_BITS);
  localparam int NSAMP_W   = $clog2(PACK_N + 1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [IN_WIDTH-1:0]  i_tdata = '0;
  logic                 i_tlast = 1'b0;
  logic                 i_tvalid = 1'b0;
  logic                 i_tready;
  logic [OUT_WIDTH-1:0] o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready = 1'b1;
  logic [NSAMP_W-1:0]   o_nsamp;

  iq_sample_packer #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_BITS (OUT_BITS),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_tdata (i_tdata),
    .i_tlast (i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tlast (o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .o_nsamp (o_nsamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    logic                 last;
    int                   nsamp;
  } word_t;

  word_t               exp_q[$];
  logic [IN_WIDTH-1:0] pkt_q[$];
  int compared   = 0;
  int mismatched = 0;
  bit rnd_ready  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference reduction: signed component scaled down by 2^(HALF-OUT_BITS).
  function automatic logic [OUT_BITS-1:0] ref_reduce(input logic [HALF-1:0] c);
    int v;
    v = int'($signed(c));
`ifdef IQ_PACK_ROUND_EN
    v = (v + (1 << (HALF - OUT_BITS - 1))) >>> (HALF - OUT_BITS);
    if (v > (1 << (OUT_BITS - 1)) - 1) v = (1 << (OUT_BITS - 1)) - 1;
`else
    v = v >>> (HALF - OUT_BITS);
`endif
    return v[OUT_BITS-1:0];
  endfunction

  // Build the expected word from the samples of the current group.
  function automatic word_t ref_word(input logic last);
    word_t w;
    logic [2*OUT_BITS-1:0] pr;
    logic [IN_WIDTH-1:0] s;
    w.data = '0;
    for (int k = 0; k < pkt_q.size(); k++) begin
      s  = pkt_q[k];
      pr = {ref_reduce(s[IN_WIDTH-1:HALF]), ref_reduce(s[HALF-1:0])};
      w.data = w.data | (OUT_WIDTH'(pr) << (OUT_WIDTH - 2 * OUT_BITS * (k + 1)));
    end
    w.last  = last;
    w.nsamp = pkt_q.size();
    return w;
  endfunction

  // Input observer: each handshake seen before the edge feeds the model.
  always @(negedge clk) begin
    if (!reset && i_tvalid && i_tready) begin
      pkt_q.push_back(i_tdata);
      if (i_tlast || pkt_q.size() == PACK_N) begin
        exp_q.push_back(ref_word(i_tlast));
        pkt_q.delete();
      end
    end
  end

  // Output monitor: compare drained words and check stall stability.
  logic                 held = 0;
  logic [OUT_WIDTH-1:0] held_data;
  logic                 held_last;
  logic [NSAMP_W-1:0]   held_nsamp;
  always @(negedge clk) begin
    word_t e;
    if (reset) begin
      held = 0;
    end else begin
      if (held) begin
        check("stall_valid", 64'(o_tvalid), 64'd1);
        check("stall_data",  64'(o_tdata),  64'(held_data));
        check("stall_last",  64'(o_tlast),  64'(held_last));
        check("stall_nsamp", 64'(o_nsamp),  64'(held_nsamp));
      end
      if (o_tvalid && !o_tready) check("stall_i_tready", 64'(i_tready), 64'd0);
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(o_tdata), 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("word_data",  64'(o_tdata), 64'(e.data));
          check("word_last",  64'(o_tlast), 64'(e.last));
          check("word_nsamp", 64'(o_nsamp), 64'(e.nsamp));
        end
      end
      held       = o_tvalid && !o_tready;
      held_data  = o_tdata;
      held_last  = o_tlast;
      held_nsamp = o_nsamp;
    end
  end

  // Random downstream backpressure during the randomized phase.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      o_tready = ($urandom_range(0, 9) < 7);
    end
  end

  // Offer one sample and wait (bounded) until it is accepted; returns just after the accepting edge.
  task automatic send(input logic [IN_WIDTH-1:0] d, input logic l);
    int n = 0;
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!i_tready && n < 300);
    if (!i_tready) check("send_timeout", 64'(i_tready), 64'd1);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, 64'(o_tvalid), 64'd0);
    check({tag, "_tdata"},  64'(o_tdata),  64'd0);
    check({tag, "_tlast"},  64'(o_tlast),  64'd0);
    check({tag, "_nsamp"},  64'(o_nsamp),  64'd0);
  endtask

  // Reset the DUT between edges and drop everything the model holds.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    pkt_q.delete();
    exp_q.delete();
    #1;
    check_outputs_zero(tag);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [IN_WIDTH-1:0] corner [6] = '{32'h7FFF_8000, 32'h8000_7FFF, 32'hFFFF_FFFF,
                                      32'h0000_0000, 32'h1800_F7FF, 32'h0FFF_0800};

  initial begin
    int n;
    logic [IN_WIDTH-1:0] d;
    #1;
    check_outputs_zero("reset_init");
    check("reset_i_tready", 64'(i_tready), 64'd1);
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full word of four samples with latency check.
    send(32'h1234_5678, 1'b0);
    send(32'h9ABC_DEF0, 1'b0);
    send(32'h0000_FFFF, 1'b0);
    check("no_early_valid", 64'(o_tvalid), 64'd0);
    send(32'h7FFF_8000, 1'b0);
    check("latency_valid", 64'(o_tvalid), 64'd1);
    check("latency_nsamp", 64'(o_nsamp),  64'd4);

    // Short packet flush, then a new word restarting at slot 0.
    send(32'hA000_B000, 1'b0);
    send(32'hC000_D000, 1'b1);
    send(32'h1000_2000, 1'b1);
    // Single-sample packet.
    send(32'h5000_6000, 1'b1);

    // Backpressure: eight samples offered while the sink stalls for ten cycles.
    fork
      begin
        send(32'h1111_2222, 1'b0);
        send(32'h3333_4444, 1'b0);
        send(32'h5555_6666, 1'b0);
        send(32'h7777_8888, 1'b0);
        send(32'h9999_AAAA, 1'b0);
        send(32'hBBBB_CCCC, 1'b0);
        send(32'hDDDD_EEEE, 1'b0);
        send(32'hFFFF_0000, 1'b1);
      end
      begin
        o_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        o_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset while a finished word is held by a stalled sink.
    o_tready = 1'b0;
    send(32'h1234_5678, 1'b0);
    send(32'h9ABC_DEF0, 1'b0);
    send(32'h0000_FFFF, 1'b0);
    send(32'h7FFF_8000, 1'b0);
    check("held_before_reset", 64'(o_tvalid), 64'd1);
    pulse_reset("reset_held");
    o_tready = 1'b1;

    // Reset with two samples partially packed; the next word must be clean.
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hEEEE_EEEE, 1'b0);
    pulse_reset("reset_partial");
    send(32'h1234_5678, 1'b0);
    send(32'h2345_6789, 1'b0);
    send(32'h3456_789A, 1'b0);
    send(32'h4567_89AB, 1'b0);
    check("post_reset_nsamp", 64'(o_nsamp), 64'd4);

    // Randomized traffic with random gaps, packet ends and backpressure.
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      d = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 5)] : IN_WIDTH'($urandom);
      send(d, (i == 299) || ($urandom_range(0, 5) == 0));
    end
    rnd_ready = 0;
    @(posedge clk);
    #1;
    o_tready = 1'b1;

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_expected_empty", 64'(exp_q.size()), 64'd0);
    check("drain_partial_empty",  64'(pkt_q.size()), 64'd0);
    check("drain_idle_valid",     64'(o_tvalid),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
